// File: rtl/redirect_ctrl.sv
// rtl/redirect_ctrl.sv - branch/jump redirect sequencer: captures an EX-stage redirect,
// waits out stalls and in-flight fetches, then issues a one-cycle PC load.
package pcmux;
   typedef enum logic [1:0] {
      pc_plus4 = 2'd0,
      alu_out  = 2'd1,
      alu_mod2 = 2'd2
   } pcmux_sel_t;
endpackage

module redirect_ctrl #(
   parameter int width = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid_i,
   input  pcmux::pcmux_sel_t   pcmux_sel_i,
   input  logic [width-1:0]    addr_i,
   input  logic                stall_i,
   input  logic                if_pending_i,
   input  logic                if_resp_i,
   output logic                pc_load_o,
   output pcmux::pcmux_sel_t   pcmux_sel_o,
   output logic [width-1:0]    target_o,
   output logic                flush_o,
   output logic                squash_resp_o,
   output logic [31:0]         redirect_cnt_o
);

   typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

   state_t            state_q, state_d;
   pcmux::pcmux_sel_t sel_q;
   logic [width-1:0]  tgt_q;
   logic [31:0]       cnt_q;
   logic              req;
   logic              capture;
   logic [width-1:0]  addr_masked;

   assign req = ex_valid_i && (pcmux_sel_i != pcmux::pc_plus4);
   // jalr targets drop bit 0; every other selection passes the address through
   assign addr_masked = addr_i & ~{{(width-1){1'b0}}, (pcmux_sel_i == pcmux::alu_mod2)};

   always_comb begin
      state_d       = state_q;
      capture       = 1'b0;
      pc_load_o     = 1'b0;
      pcmux_sel_o   = pcmux::pc_plus4;
      flush_o       = 1'b0;
      squash_resp_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && rst) begin
               capture = 1'b1;
               flush_o = 1'b1;
               state_d = (!stall_i && !if_pending_i) ? ISSUE : WAIT;
            end
         end
         WAIT: begin
            flush_o       = 1'b1;
            squash_resp_o = if_resp_i;
            // a stalled pipeline cannot take the load, even if the fetch has returned
            if (!stall_i && (!if_pending_i || if_resp_i)) state_d = ISSUE;
         end
         ISSUE: begin
            flush_o     = 1'b1;
            pc_load_o   = 1'b1;
            pcmux_sel_o = sel_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sel_q   <= pcmux::pc_plus4;
         tgt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            sel_q <= pcmux_sel_i;
            tgt_q <= addr_masked;
         end
         if (state_q == ISSUE) cnt_q <= cnt_q + 32'd1;
      end
   end

   assign target_o       = tgt_q;
   assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb/tb_redirect_ctrl.sv - randomized and directed bench for redirect_ctrl with a
// transaction-level reference model and a queue-based scoreboard.
module tb_redirect_ctrl;
   import pcmux::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              ex_valid_i = 1'b0;
   pcmux_sel_t        pcmux_sel_i = pc_plus4;
   logic [31:0]       addr_i = '0;
   logic              stall_i = 1'b0;
   logic              if_pending_i = 1'b0;
   logic              if_resp_i = 1'b0;
   logic              pc_load_o;
   pcmux_sel_t        pcmux_sel_o;
   logic [31:0]       target_o;
   logic              flush_o;
   logic              squash_resp_o;
   logic [31:0]       redirect_cnt_o;

   redirect_ctrl #(.width(32)) dut (
      .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .pcmux_sel_i(pcmux_sel_i),
      .addr_i(addr_i), .stall_i(stall_i), .if_pending_i(if_pending_i),
      .if_resp_i(if_resp_i), .pc_load_o(pc_load_o), .pcmux_sel_o(pcmux_sel_o),
      .target_o(target_o), .flush_o(flush_o), .squash_resp_o(squash_resp_o),
      .redirect_cnt_o(redirect_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        load;
      logic [1:0]  sel;
      logic [31:0] tgt;
      logic        flush;
      logic        squash;
      logic [31:0] cnt;
   } cyc_t;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] tgt;
   } redir_t;

   cyc_t   cq[$];
   redir_t rq[$];
   int     vectors = 0;
   int     miscompares = 0;

   // model: a redirect is either absent, held back, or due this cycle
   logic        m_held = 1'b0;
   logic        m_due = 1'b0;
   logic [1:0]  m_sel = 2'd0;
   logic [31:0] m_tgt = '0;
   logic [31:0] m_cnt = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic v, input pcmux_sel_t s, input logic [31:0] a,
                       input logic st, input logic ip, input logic ir);
      cyc_t   e;
      redir_t rd;
      logic   new_req;
      rst = r; ex_valid_i = v; pcmux_sel_i = s; addr_i = a;
      stall_i = st; if_pending_i = ip; if_resp_i = ir;
      if (!r) begin
         m_held = 0; m_due = 0; m_sel = 2'd0; m_tgt = '0; m_cnt = '0;
         rq.delete();
         e = '{load: 0, sel: 2'd0, tgt: 0, flush: 0, squash: 0, cnt: 0};
      end else begin
         new_req = !m_held && !m_due && v && (s != pc_plus4);
         e.load   = m_due;
         e.sel    = m_due ? m_sel : 2'd0;
         e.tgt    = m_tgt;
         e.flush  = m_held || m_due || new_req;
         e.squash = m_held && ir;
         e.cnt    = m_cnt;
         if (m_due) begin
            m_due = 0;
            m_cnt = m_cnt + 1;
         end else if (m_held) begin
            if (!st && (!ip || ir)) begin
               m_held = 0;
               m_due  = 1;
            end
         end else if (new_req) begin
            m_sel = s;
            m_tgt = (s == alu_mod2) ? {a[31:1], 1'b0} : a;
            rd.sel = m_sel;
            rd.tgt = m_tgt;
            rq.push_back(rd);
            if (!st && !ip) m_due = 1;
            else m_held = 1;
         end
      end
      cq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, pc_plus4, 32'h0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      cyc_t   e;
      redir_t rd;
      if (cq.size() > 0) begin
         e = cq.pop_front();
         chk("pc_load", {31'd0, pc_load_o}, {31'd0, e.load});
         chk("pcmux_sel", {30'd0, pcmux_sel_o}, {30'd0, e.sel});
         chk("target", target_o, e.tgt);
         chk("flush", {31'd0, flush_o}, {31'd0, e.flush});
         chk("squash_resp", {31'd0, squash_resp_o}, {31'd0, e.squash});
         chk("redirect_cnt", redirect_cnt_o, e.cnt);
      end
      if (pc_load_o === 1'b1) begin
         if (rq.size() == 0) begin
            chk("unexpected_load", 32'd1, 32'd0);
         end else begin
            rd = rq.pop_front();
            chk("issued_sel", {30'd0, pcmux_sel_o}, {30'd0, rd.sel});
            chk("issued_target", target_o, rd.tgt);
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      step(0, 1, alu_out, 32'hDEAD_BEEF, 0, 0, 0);
      step(0, 0, pc_plus4, 32'h0, 0, 0, 0);
      idle(2);
      // taken branch, no hazards
      step(1, 1, alu_out, 32'h0000_1040, 0, 0, 0);
      idle(2);
      // jalr with odd target
      step(1, 1, alu_mod2, 32'h0000_2003, 0, 0, 0);
      idle(2);
      // outstanding fetch, response three cycles later
      step(1, 1, alu_out, 32'h0000_3000, 0, 1, 0);
      step(1, 0, pc_plus4, 32'h0, 0, 1, 0);
      step(1, 0, pc_plus4, 32'h0, 0, 1, 0);
      step(1, 0, pc_plus4, 32'h0, 0, 1, 1);
      idle(2);
      // stall for four cycles with a response landing mid-stall
      step(1, 1, alu_out, 32'h0000_4444, 1, 1, 0);
      step(1, 0, pc_plus4, 32'h0, 1, 1, 1);
      step(1, 0, pc_plus4, 32'h0, 1, 0, 0);
      step(1, 0, pc_plus4, 32'h0, 1, 0, 0);
      step(1, 0, pc_plus4, 32'h0, 0, 0, 0);
      idle(2);
      // second request while waiting must be ignored
      step(1, 1, alu_out, 32'h0000_5000, 1, 0, 0);
      step(1, 1, alu_mod2, 32'h0000_6001, 1, 0, 0);
      step(1, 1, alu_out, 32'h0000_7000, 0, 0, 0);
      // back-to-back: new request in the cycle right after issue
      step(1, 0, pc_plus4, 32'h0, 0, 0, 0);
      step(1, 1, alu_out, 32'h0000_8000, 0, 0, 0);
      step(1, 0, pc_plus4, 32'h0, 0, 0, 0);
      step(1, 1, alu_mod2, 32'h0000_9009, 0, 0, 0);
      idle(2);
      // reset while waiting, then no load after release
      step(1, 1, alu_out, 32'h0000_A000, 0, 1, 0);
      step(1, 0, pc_plus4, 32'h0, 0, 1, 0);
      step(0, 1, alu_out, 32'h0000_B000, 0, 0, 1);
      step(0, 0, pc_plus4, 32'h0, 0, 0, 0);
      idle(3);
      // counter wrap
      force dut.cnt_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      idle(1);
      release dut.cnt_q;
      step(1, 1, alu_out, 32'h0000_C000, 0, 0, 0);
      idle(3);
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 149) != 0), 1'($urandom_range(0, 1)),
              pcmux_sel_t'($urandom_range(0, 2)), $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 2) == 0));
      end
      idle(4);
      @(negedge clk);
      #1;
      chk("redirects_outstanding", rq.size(), 32'd0);
      chk("cycles_outstanding", cq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 SHALL have parameter: width, default 32, address/data width.
REQ-002 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ex_valid_i  input  1  EX stage holds a valid instruction this cycle.
REQ-005 SHALL have port: pcmux_sel_i  input  pcmux::pcmux_sel_t  branch-resolver PC select for the EX instruction.
REQ-006 SHALL have port: addr_i  input  width  branch-resolver computed target.
REQ-007 SHALL have port: stall_i  input  1  global pipeline freeze (data-memory stall).
REQ-008 SHALL have port: if_pending_i  input  1  instruction fetch outstanding, response not yet returned.
REQ-009 SHALL have port: if_resp_i  input  1  instruction-memory response valid this cycle.
REQ-010 SHALL have port: pc_load_o  output  1  load PC with target_o this cycle.
REQ-011 SHALL have port: pcmux_sel_o  output  pcmux::pcmux_sel_t  PC mux select.
REQ-012 SHALL have port: target_o  output  width  redirect address.
REQ-013 SHALL have port: flush_o  output  1  bubble IF/ID and ID/EX (wrong-path kill).
REQ-014 SHALL have port: squash_resp_o  output  1  discard the current fetch response.
REQ-015 SHALL have port: redirect_cnt_o  output  32  count of issued redirects.

Function
REQ-016 SHALL treat a redirect request as ex_valid_i=1 and pcmux_sel_i != pcmux::pc_plus4, sampled only in IDLE.
REQ-017 SHALL implement states IDLE, WAIT, ISSUE; reset state IDLE.
REQ-018 SHALL, on a request in IDLE, register pcmux_sel_i and addr_i (bit 0 cleared when pcmux_sel_i = alu_mod2, all other bits unchanged).
REQ-019 SHALL transition IDLE->ISSUE on a request when stall_i=0 and if_pending_i=0; IDLE->WAIT on a request otherwise.
REQ-020 SHALL transition WAIT->ISSUE in the first cycle with stall_i=0 and (if_pending_i=0 or if_resp_i=1); otherwise remain in WAIT.
REQ-021 SHALL assert squash_resp_o exactly in cycles where state is WAIT and if_resp_i=1; squash_resp_o=0 in all other states.
REQ-022 SHALL, in ISSUE, assert pc_load_o=1 for exactly one cycle, drive pcmux_sel_o and target_o from the captured registers, then return to IDLE unconditionally.
REQ-023 SHALL drive pc_load_o=0 and pcmux_sel_o=pcmux::pc_plus4 outside ISSUE; target_o holds the last captured value.
REQ-024 SHALL assert flush_o in the request cycle (IDLE with request) and in every WAIT and ISSUE cycle; flush_o=0 otherwise.
REQ-025 SHALL give a minimum request-to-pc_load_o latency of exactly 1 cycle.
REQ-026 SHALL ignore ex_valid_i and pcmux_sel_i while in WAIT or ISSUE; no second capture, no captured value overwritten.
REQ-027 SHALL accept a new request in the IDLE cycle immediately following ISSUE (back-to-back redirects).
REQ-028 SHALL increment redirect_cnt_o by 1 in each ISSUE cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-029 SHALL give stall_i priority over if_resp_i in WAIT: a response during stall is squashed, and the exit from WAIT waits for stall_i=0.

Reset
REQ-030 SHALL, on rst=0 at any time including mid-WAIT/ISSUE, immediately force state IDLE, pc_load_o=0, pcmux_sel_o=pc_plus4, target_o=0, flush_o=0, squash_resp_o=0, redirect_cnt_o=0.
REQ-031 SHALL resume sampling requests on the first rising clk edge after rst returns to 1.

Verification
REQ-032 SHALL cover: taken op_br, addr_i=0x0000_1040, stall_i=0, if_pending_i=0 -> next cycle pc_load_o=1, pcmux_sel_o=alu_out, target_o=0x0000_1040, flush_o high both cycles, redirect_cnt_o=1.
REQ-033 SHALL cover: jalr, pcmux_sel_i=alu_mod2, addr_i=0x0000_2003 -> target_o=0x0000_2002, pcmux_sel_o=alu_mod2.
REQ-034 SHALL cover: request with if_pending_i=1, if_resp_i after 3 cycles -> squash_resp_o=1 in that cycle only, pc_load_o the following cycle, flush_o high throughout.
REQ-035 SHALL cover: request with stall_i=1 for 4 cycles, if_resp_i during stall -> squash_resp_o in that cycle, pc_load_o 1 cycle after stall_i falls.
REQ-036 SHALL cover: second taken request during WAIT -> ignored, first target issued; rst=0 mid-WAIT -> all outputs reset values, no pc_load_o after release; counter at 0xFFFF_FFFF + one issue -> 0.
